// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave register file with byte-strobed writes and independent read/write channels.
// Define AXIL_ADDR_CHECK_EN to return SLVERR for out-of-range indices instead of wrapping.
module axi4_lite_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic [DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFFS       = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = $clog2(NUM_REGS);

`ifdef AXIL_ADDR_CHECK_EN
  localparam logic ADDR_CHECK = 1'b1;
`else
  localparam logic ADDR_CHECK = 1'b0;
`endif

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] HAVE_ADDR = 2'd1;
  localparam logic [1:0] HAVE_DATA = 2'd2;
  localparam logic [1:0] RESP      = 2'd3;

  logic [1:0]            state;
  logic                  live;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_hs, w_hs, ar_hs, commit, wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_word, rd_word;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [IDX_WIDTH-1:0]  wr_idx, rd_idx;
  logic                  wr_ok, rd_ok;

  // live keeps every ready low while reset is held and for the release cycle.
  assign AWREADY = live && (state == IDLE || state == HAVE_DATA);
  assign WREADY  = live && (state == IDLE || state == HAVE_ADDR);
  assign ARREADY = live && !rvalid_q;
  assign BVALID  = (state == RESP);
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign ar_hs  = ARVALID && ARREADY;
  assign commit = (state == IDLE && aw_hs && w_hs) ||
                  (state == HAVE_ADDR && w_hs) ||
                  (state == HAVE_DATA && aw_hs);

  // The half that arrived first comes from its latch, the other straight from the bus.
  assign wr_addr = (state == HAVE_ADDR) ? awaddr_q : AWADDR;
  assign wr_data = (state == HAVE_DATA) ? wdata_q : WDATA;
  assign wr_strb = (state == HAVE_DATA) ? wstrb_q : WSTRB;

  assign wr_word = wr_addr >> OFFS;
  assign rd_word = ARADDR >> OFFS;
  assign wr_idx  = wr_word[IDX_WIDTH-1:0];
  assign rd_idx  = rd_word[IDX_WIDTH-1:0];
  assign wr_ok   = {1'b0, wr_word} < (ADDR_WIDTH+1)'(NUM_REGS);
  assign rd_ok   = {1'b0, rd_word} < (ADDR_WIDTH+1)'(NUM_REGS);
  assign wr_en   = commit && (wr_ok || !ADDR_CHECK);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= IDLE;
      live     <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= 2'b00;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: begin
          if (aw_hs && w_hs) state <= RESP;
          else if (aw_hs)    state <= HAVE_ADDR;
          else if (w_hs)     state <= HAVE_DATA;
        end
        HAVE_ADDR: if (w_hs)   state <= RESP;
        HAVE_DATA: if (aw_hs)  state <= RESP;
        RESP:      if (BREADY) state <= IDLE;
        default:               state <= IDLE;
      endcase
      if (aw_hs) awaddr_q <= AWADDR;
      if (w_hs) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
      if (commit) bresp_q <= (ADDR_CHECK && !wr_ok) ? 2'b10 : 2'b00;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wr_strb[b]) regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Reads sample regs before any same-edge write lands, so they see the old value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= (rd_ok || !ADDR_CHECK) ? regs[rd_idx] : '0;
      rresp_q  <= (ADDR_CHECK && !rd_ok) ? 2'b10 : 2'b00;
    end else if (rvalid_q && RREADY) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end
  end

endmodule

// File: doc/axi4_lite_regfile.md
AXI4_LITE_REGFILE -- requirements
Module: axi4_lite_regfile
Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data bus width; legal values 8, 16, 32, 64.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the byte-address width.
REQ-003 Parameter NUM_REGS, default 16, SHALL set the register count; power of 2, and NUM_REGS*DATA_WIDTH/8 <= 2^ADDR_WIDTH.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low: ACLK input 1 clock, all logic on the rising edge.
REQ-005 ARESETN  input  1  asynchronous active-low reset.
REQ-006 AWADDR  input  ADDR_WIDTH  write byte address.
REQ-007 AWVALID  input  1 / AWREADY  output  1  write-address handshake.
REQ-008 WDATA  input  DATA_WIDTH  write data.
REQ-009 WSTRB  input  DATA_WIDTH/8  byte-lane write enables.
REQ-010 WVALID  input  1 / WREADY  output  1  write-data handshake.
REQ-011 BRESP  output  2  write response; BVALID  output  1; BREADY  input  1.
REQ-012 ARADDR  input  ADDR_WIDTH  read byte address.
REQ-013 ARVALID  input  1 / ARREADY  output  1  read-address handshake.
REQ-014 RDATA  output  DATA_WIDTH  read data; RRESP  output  2.
REQ-015 RVALID  output  1 / RREADY  input  1  read-data handshake.
Function
REQ-016 Register index SHALL be addr >> log2(DATA_WIDTH/8); low byte-offset bits ignored.
REQ-017 AWREADY SHALL be high whenever no address is latched and BVALID is low; WREADY likewise for data; the two channels SHALL be accepted independently, in either order or the same cycle.
REQ-018 On the edge completing the second of the AW/W handshakes, the write SHALL commit, each byte lane updated only where its WSTRB bit is 1, and BVALID SHALL rise on that same edge (latency 1 cycle after both handshakes in same cycle).
REQ-019 BVALID SHALL hold with BRESP stable until BVALID&&BREADY; no new AW or W SHALL be accepted while BVALID is high.
REQ-020 Write FSM states: IDLE, HAVE_ADDR, HAVE_DATA, RESP; IDLE->HAVE_ADDR/HAVE_DATA on one handshake, ->RESP on both or the missing half, RESP->IDLE on BREADY.
REQ-021 ARREADY SHALL equal !RVALID; on ARVALID&&ARREADY, RDATA/RRESP SHALL be registered and RVALID SHALL rise on that edge.
REQ-022 RVALID, RDATA, RRESP SHALL hold stable until RVALID&&RREADY; RDATA SHALL be 0 while RVALID is low.
REQ-023 Read and write channels SHALL operate concurrently; a read handshake on the same edge as a write commit to the same register SHALL return the pre-write value.
REQ-024 WSTRB = 0 SHALL complete the handshake with OKAY and leave the register unchanged.
Reset
REQ-025 While ARESETN is low: all registers 0, AWREADY/WREADY/ARREADY/BVALID/RVALID 0, BRESP/RRESP 2'b00, RDATA 0; ready outputs SHALL go high on the first rising edge after deassertion.
REQ-026 Reset asserted mid-transaction SHALL discard any latched AW/W half and pending B/R response; the FSM SHALL return to IDLE.
Configuration
REQ-027 With AXIL_ADDR_CHECK_EN defined: an index >= NUM_REGS SHALL give BRESP/RRESP = 2'b10 (SLVERR), write discarded, RDATA = 0.
REQ-028 Without AXIL_ADDR_CHECK_EN: the index SHALL wrap modulo NUM_REGS and responses SHALL always be 2'b00 (OKAY).
Verification (DATA_WIDTH=32, ADDR_WIDTH=8, NUM_REGS=16)
REQ-029 After reset, read 0x00 -> RDATA 0x00000000, RRESP 00, RVALID one cycle after the AR handshake.
REQ-030 Write 0x10 = 0xDEADBEEF, WSTRB 0xF, then WSTRB 0x2 data 0x00005500, then read 0x10 -> 0xDEAD55EF, both BRESP 00.
REQ-031 AW to 0x08 issued 3 cycles before W 0x12345678 -> BVALID rises on the W handshake edge; with BREADY low for 4 cycles BVALID held, AWREADY low throughout.
REQ-032 Same-cycle write 0x20 = 0xAA and read 0x20 after reset -> read returns 0x00000000; a subsequent read returns 0x000000AA.
REQ-033 Write/read 0x40: with AXIL_ADDR_CHECK_EN -> BRESP 10, RRESP 10, RDATA 0, register 0 unchanged; without -> aliases register 0, responses 00.
REQ-034 ARESETN pulsed low while AW latched without W -> after release, W alone produces no BVALID; registers all 0.
